secret_arbiter: RTL
===================

# secret_arbiter

Round-robin controller that shares one `verilated_secret`-style 32-bit two-operand datapath between up to NUM_REQ requesters. It holds the datapath in reset after system reset, then accepts one operand pair at a time through a valid/ready handshake. It drives the pair into the datapath and waits a fixed latency. It then returns the datapath result to the granted requester through a valid/ready response channel. It sits between the test/stimulus layer and the protected datapath instance, replacing direct per-cycle operand driving.

## Interface
- NUM_REQ, 2 — number of requesters, 2..4.
- LATENCY, 1 — cycles from operands driven to `dp_x` valid, 1..15.
- RST_CYCLES, 2 — cycles `dp_reset_l` is held low after `reset`, 1..15.

- clk  in  1  — single clock, all logic on posedge.
- reset  in  1  — synchronous, active-high.
- req_valid  in  NUM_REQ  — per-requester operand pair valid.
- req_ready  out  NUM_REQ  — one-hot grant; a transfer occurs when req_valid[i] & req_ready[i].
- req_a  in  NUM_REQ*32  — operand a, requester i at bits [32i+31:32i].
- req_b  in  NUM_REQ*32  — operand b, same packing as req_a.
- rsp_valid  out  NUM_REQ  — one-hot response valid.
- rsp_ready  in  NUM_REQ  — per-requester response accept.
- rsp_x  out  32  — result, qualified by rsp_valid.
- dp_reset_l  out  1  — datapath reset, active-low.
- dp_a, dp_b  out  32  — datapath operands.
- dp_x  in  32  — datapath result.
- busy  out  1  — high in every state except IDLE.

## Operation
- States are INIT, IDLE, ISSUE, WAIT and RESP.
- **INIT**, entered on reset:
  - `dp_reset_l`=0 for RST_CYCLES cycles, counted by a 4-bit down-counter; then go to IDLE.
  - `dp_reset_l`=1 in every other state.
- **IDLE**:
  - Round-robin scan starts at pointer `rr_ptr`; the first i with req_valid[i] gets req_ready[i]=1. req_ready is combinational from req_valid and rr_ptr, and is never asserted outside IDLE.
  - On the transfer: latch a/b and grant index g; set rr_ptr ← (g+1) mod NUM_REQ; go to ISSUE.
- **ISSUE**, 1 cycle:
  - `dp_a`/`dp_b` are driven from the latches and held stable through WAIT.
  - Go to WAIT with the latency counter loaded to LATENCY-1.
- **WAIT**:
  - Decrement the counter.
  - At 0, capture `dp_x` into the result register and go to RESP.
- **RESP**:
  - rsp_valid[g]=1 and rsp_x=result are held stable until rsp_ready[g].
  - Then go to IDLE.
- In IDLE and INIT, `dp_a`/`dp_b` are driven to 0.
- A requester's rsp_ready while its rsp_valid is low has no effect.
- Deasserting req_valid without a transfer is legal and has no effect.
- `reset` mid-operation: the in-flight transaction is dropped with no response; go to INIT and re-pulse `dp_reset_l`.

## Timing
- Reset values:
  - req_ready=0, rsp_valid=0, rsp_x=0, dp_a=dp_b=0.
  - dp_reset_l=0, busy=1.
  - rr_ptr=0, state INIT.
- Transfer at cycle T:
  - dp_a/dp_b valid from T+1.
  - dp_x sampled at the end of cycle T+1+LATENCY.
  - rsp_valid asserted at T+2+LATENCY.
- Response accepted at cycle R: the next grant is possible at R+1. Minimum issue interval is LATENCY+3 cycles.
- First grant is possible RST_CYCLES cycles after `reset` deasserts.

## Configuration
- `SECRET_ARB_STATS_EN` defined:
  - Adds output `grant_count`, NUM_REQ×16 bits packed.
  - It holds per-requester saturating counters incremented on each transfer, with reset value 0.
  - Saturation is at 16'hFFFF, with no wrap.
- Macro undefined: the port and counters are absent, and behaviour is otherwise identical.

## Structure
- Package `secret_arb_pkg`:
  - state enum `secret_arb_state_e` (INIT, IDLE, ISSUE, WAIT, RESP);
  - `DATA_W`=32;
  - `MAX_REQ`=4.
- Sub-module `secret_arb_rr` holds the combinational round-robin priority picker: inputs req_valid and rr_ptr; outputs one-hot grant and index.

## Test plan
Use NUM_REQ=2, LATENCY=1, RST_CYCLES=2 and a reference datapath model.
1. Reset release: dp_reset_l is low for exactly 2 cycles, then high; busy falls on the same edge; req_ready is 0 throughout.
2. Single request: req 0 sends a=5, b=7 at T; dp_a=5, dp_b=7 from T+1; rsp_valid=2'b01 at T+3 with rsp_x equal to the model output for (5,7).
3. Contention: both requesters valid continuously with (6,2) and (1,9); grants alternate 0,1,0,1, each one-hot, with rr_ptr starting at 0.
4. Response backpressure: rsp_ready[0] held low for 5 cycles; rsp_valid and rsp_x stay stable; req_ready stays 0 for both requesters until acceptance.
5. Mid-operation reset: assert reset during WAIT; no rsp_valid follows; the INIT sequence repeats; the next request completes correctly.
6. With `SECRET_ARB_STATS_EN` defined: 3 grants to requester 1 give grant_count[1]=3; a forced near-saturation value shows the counter hold at 16'hFFFF.

Source files
------------

// File: rtl/secret_arb_pkg.sv
// Shared types and constants for the secret_arbiter datapath controller.
package secret_arb_pkg;

  localparam int DATA_W  = 32;
  localparam int MAX_REQ = 4;
  localparam int IDX_W   = $clog2(MAX_REQ);
  localparam int CNT_W   = 4;
  localparam int STAT_W  = 16;

  typedef enum logic [2:0] {
    INIT  = 3'd0,
    IDLE  = 3'd1,
    ISSUE = 3'd2,
    WAIT  = 3'd3,
    RESP  = 3'd4
  } secret_arb_state_e;

  // Advance a requester index by one, wrapping at n.
  function automatic logic [IDX_W-1:0] wrap_inc(logic [IDX_W-1:0] v, int n);
    return (int'(v) == n - 1) ? '0 : v + IDX_W'(1);
  endfunction

endpackage

// File: rtl/secret_arb_rr.sv
// Combinational round-robin picker: the first valid requester at or after
// the pointer (wrapping) wins. Produces a one-hot grant plus its index.
module secret_arb_rr
  import secret_arb_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0] req_valid_i,
  input  logic [IDX_W-1:0]   rr_ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDX_W-1:0]   grant_idx_o,
  output logic               grant_vld_o
);

  // Scan priority slots k = 0.. starting from the pointer; the slot maps to
  // requester (ptr + k) mod NUM_REQ. The first valid one takes the grant.
  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    grant_vld_o = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!grant_vld_o && req_valid_i[i] &&
            (i == (int'(rr_ptr_i) + k) % NUM_REQ)) begin
          grant_vld_o = 1'b1;
          grant_o[i]  = 1'b1;
          grant_idx_o = IDX_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/secret_arbiter.sv
// Round-robin controller sharing one two-operand datapath among NUM_REQ
// requesters: INIT pulses the datapath reset, IDLE grants, ISSUE/WAIT drive
// operands for LATENCY cycles, RESP hands the result back.
// Optional build macro SECRET_ARB_STATS_EN adds per-requester saturating
// grant counters on output grant_count.
module secret_arbiter
  import secret_arb_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int LATENCY    = 1,
  parameter int RST_CYCLES = 2
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [NUM_REQ-1:0][DATA_W-1:0]  req_a,
  input  logic [NUM_REQ-1:0][DATA_W-1:0]  req_b,
  output logic [NUM_REQ-1:0]              rsp_valid,
  input  logic [NUM_REQ-1:0]              rsp_ready,
  output logic [DATA_W-1:0]               rsp_x,
  output logic                            dp_reset_l,
  output logic [DATA_W-1:0]               dp_a,
  output logic [DATA_W-1:0]               dp_b,
  input  logic [DATA_W-1:0]               dp_x,
  output logic                            busy
`ifdef SECRET_ARB_STATS_EN
  ,
  output logic [NUM_REQ-1:0][STAT_W-1:0]  grant_count
`endif
);

  secret_arb_state_e    state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;     // INIT reset timer and WAIT latency timer
  logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;     // one-hot owner of the in-flight op
  logic [DATA_W-1:0]    a_q, a_d;
  logic [DATA_W-1:0]    b_q, b_d;
  logic [DATA_W-1:0]    x_q, x_d;

  logic [NUM_REQ-1:0]   pick_gnt;
  logic [IDX_W-1:0]     pick_idx;
  logic                 pick_vld;
  logic                 xfer;

  secret_arb_rr #(.NUM_REQ(NUM_REQ)) u_rr (
    .req_valid_i (req_valid),
    .rr_ptr_i    (rr_ptr_q),
    .grant_o     (pick_gnt),
    .grant_idx_o (pick_idx),
    .grant_vld_o (pick_vld)
  );

  assign rsp_x = x_q;

  // Next-state and output decode for the controller FSM.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rr_ptr_d   = rr_ptr_q;
    gnt_d      = gnt_q;
    a_d        = a_q;
    b_d        = b_q;
    x_d        = x_q;
    req_ready  = '0;
    rsp_valid  = '0;
    dp_reset_l = 1'b1;
    dp_a       = '0;
    dp_b       = '0;
    busy       = 1'b1;
    xfer       = 1'b0;
    unique case (state_q)
      INIT: begin
        dp_reset_l = 1'b0;
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      IDLE: begin
        busy      = 1'b0;
        req_ready = pick_gnt;
        if (pick_vld) begin
          xfer     = 1'b1;
          gnt_d    = pick_gnt;
          rr_ptr_d = wrap_inc(pick_idx, NUM_REQ);
          for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_gnt[i]) begin
              a_d = req_a[i];
              b_d = req_b[i];
            end
          end
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        dp_a    = a_q;
        dp_b    = b_q;
        cnt_d   = CNT_W'(LATENCY - 1);
        state_d = WAIT;
      end
      WAIT: begin
        dp_a = a_q;
        dp_b = b_q;
        if (cnt_q == '0) begin
          x_d     = dp_x;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        // Operands stay on the datapath until the result is taken.
        dp_a      = a_q;
        dp_b      = b_q;
        rsp_valid = gnt_q;
        if ((rsp_ready & gnt_q) != '0) state_d = IDLE;
      end
      default: begin
        state_d = INIT;
        cnt_d   = CNT_W'(RST_CYCLES - 1);
      end
    endcase
  end

  // Controller state; reset drops any in-flight op and restarts the INIT pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= INIT;
      cnt_q    <= CNT_W'(RST_CYCLES - 1);
      rr_ptr_q <= '0;
      gnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      x_q      <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rr_ptr_q <= rr_ptr_d;
      gnt_q    <= gnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      x_q      <= x_d;
    end
  end

`ifdef SECRET_ARB_STATS_EN
  logic [NUM_REQ-1:0][STAT_W-1:0] gcnt_q, gcnt_d;

  // Per-requester grant counters, saturating at all-ones.
  always_comb begin
    gcnt_d = gcnt_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (xfer && pick_gnt[i] && (gcnt_q[i] != '1)) gcnt_d[i] = gcnt_q[i] + STAT_W'(1);
    end
  end

  // Grant counter registers.
  always_ff @(posedge clk) begin
    if (reset) gcnt_q <= '0;
    else       gcnt_q <= gcnt_d;
  end

  assign grant_count = gcnt_q;
`else
  logic unused_xfer;
  assign unused_xfer = xfer;
`endif

endmodule
